// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Places loads and stores on a valid/ready memory bus and holds the pipeline
// while a transaction is outstanding. Load data is formatted (byte/half/word,
// sign or zero extended) before the MEM/WB register. Misalignment, bus errors
// and timeouts are reported as one-cycle exception pulses.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        kill_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_rdata_i,
  input  logic        rsp_err_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_exc_o,
  output logic        bus_err_exc_o
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  // Last count value still spent waiting; reaching it with no response aborts.
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t        state_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic          kill_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   load_data_q;

  logic          req;
  logic          is_store;
  logic          legal;
  logic          aligned;
  logic          accept;
  logic          reject;
  logic [3:0]    wstrb_d;
  logic [31:0]   wdata_d;
  logic [7:0]    rsp_byte;
  logic [15:0]   rsp_half;
  logic [31:0]   fmt_data;

  // Decode the MEM-stage request: legality, alignment and store lane setup.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    req      = (mem_read_i | mem_write_i) & ~kill_i;
    is_store = mem_write_i;
    aligned  = 1'b0;
    wstrb_d  = 4'b0000;
    wdata_d  = wdata_i;
    // Loads allow 000,001,010,100,101; stores allow only 000,001,010.
    if (is_store) legal = ~funct3_i[2] & (funct3_i[1:0] != 2'b11);
    else          legal = (funct3_i[1:0] != 2'b11) & ~(funct3_i[2] & funct3_i[1]);
    case (funct3_i[1:0])
      2'b00: begin
        aligned = 1'b1;
        wdata_d = {4{wdata_i[7:0]}};
        wstrb_d = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        aligned = ~addr_i[0];
        wdata_d = {2{wdata_i[15:0]}};
        wstrb_d = 4'b0011 << addr_i[1:0];
      end
      2'b10: begin
        aligned = (addr_i[1:0] == 2'b00);
        wstrb_d = 4'b1111;
      end
      default: ;
    endcase
    if (!is_store) wstrb_d = 4'b0000;
    accept = (state_q == IDLE) & req & legal & aligned;
    reject = (state_q == IDLE) & req & ~(legal & aligned);
  end

  // Extract the addressed lane of the response word and extend it.
  always_comb begin
    rsp_byte = rsp_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    rsp_half = rsp_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  fmt_data = {{24{rsp_byte[7]}}, rsp_byte};
      3'b001:  fmt_data = {{16{rsp_half[15]}}, rsp_half};
      3'b100:  fmt_data = {24'h000000, rsp_byte};
      3'b101:  fmt_data = {16'h0000, rsp_half};
      default: fmt_data = rsp_rdata_i;
    endcase
  end

  // Transaction sequencer: IDLE -> REQ -> WAIT_RSP -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      kill_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q   <= addr_i;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            funct3_q <= funct3_i;
            we_q     <= is_store;
            kill_q   <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          // Once the bus has accepted, the transaction must complete; a kill
          // in the same cycle only suppresses the final pulses.
          if (bus_ready_i) begin
            cnt_q   <= '0;
            kill_q  <= kill_i;
            state_q <= WAIT_RSP;
          end else if (kill_i) begin
            state_q <= IDLE;
          end
        end
        WAIT_RSP: begin
          if (kill_i) kill_q <= 1'b1;
          if (rsp_valid_i) begin
            err_q   <= rsp_err_i;
            state_q <= DONE;
            // Only a load that will be reported updates the result register.
            if (!we_q && !rsp_err_i && !kill_q && !kill_i) load_data_q <= fmt_data;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // The same instruction is still presented this cycle; ignore it.
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_valid_o    = (state_q == REQ);
  assign bus_we_o       = we_q;
  assign bus_addr_o     = {addr_q[31:2], 2'b00};
  assign bus_wdata_o    = wdata_q;
  assign bus_wstrb_o    = wstrb_q;
  assign load_data_o    = load_data_q;
  // Combinational terms are gated by rstn so every output reads 0 during reset.
  assign stall_o        = rstn & (accept | (state_q == REQ) | (state_q == WAIT_RSP));
  assign misalign_exc_o = rstn & reject;
  assign load_valid_o   = (state_q == DONE) & ~we_q & ~err_q & ~kill_q;
  assign bus_err_exc_o  = (state_q == DONE) & err_q & ~kill_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: table-driven vectors, directed
// multi-cycle corner cases and randomized transactions against a
// transaction-level reference model.
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read_i, mem_write_i, kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        bus_valid_o, bus_ready_i, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        rsp_valid_i, rsp_err_i;
  logic [31:0] rsp_rdata_i;
  logic        stall_o, load_valid_o, misalign_exc_o, bus_err_exc_o;
  logic [31:0] load_data_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_last = '0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .kill_i(kill_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i), .rsp_err_i(rsp_err_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .misalign_exc_o(misalign_exc_o), .bus_err_exc_o(bus_err_exc_o)
  );

  // Observed (or expected) summary of one transaction.
  typedef struct {
    int          stall_cycles, valid_cycles, lv_cnt, be_cnt, mis_cnt, ev_cyc;
    logic [31:0] addr, wdata, data;
    logic [3:0]  strb;
    logic        we, stable, finished;
  } obs_t;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_lv;
    logic [31:0] exp_data;
    logic        exp_be;
    int          exp_stall;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic obs_t empty_obs();
    obs_t o;
    o.stall_cycles = 0; o.valid_cycles = 0; o.lv_cnt = 0; o.be_cnt = 0;
    o.mis_cnt = 0; o.ev_cyc = -1; o.addr = '0; o.wdata = '0; o.data = '0;
    o.strb = '0; o.we = 1'b0; o.stable = 1'b1; o.finished = 1'b0;
    return o;
  endfunction

  // Reference model: outcome of one transaction from the access rules alone.
  function automatic obs_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic err,
                                 input int ready_dly, input int rsp_dly,
                                 input logic kill_req, input logic kill_wait);
    obs_t e;
    int nbytes, wait_cycles;
    logic legal, aligned, timed_out;
    logic [31:0] v;
    e = empty_obs();
    e.finished = 1'b1;
    if (!(rd | wr)) return e;
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    nbytes  = 1 << f3[1:0];
    aligned = ((addr % nbytes) == 0);
    if (!legal || !aligned) begin
      e.mis_cnt = 1;
      return e;
    end
    e.we   = wr;
    e.addr = addr & 32'hFFFF_FFFC;
    e.strb = wr ? 4'(((1 << nbytes) - 1) << (addr % 4)) : 4'b0000;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    if (kill_req) begin
      e.valid_cycles = 1;
      e.stall_cycles = 2;
      return e;
    end
    e.valid_cycles = ready_dly + 1;
    timed_out      = (rsp_dly >= TIMEOUT);
    wait_cycles    = timed_out ? TIMEOUT : rsp_dly + 1;
    e.stall_cycles = 1 + e.valid_cycles + wait_cycles;
    e.ev_cyc       = e.stall_cycles;
    if (!kill_wait) begin
      if (timed_out || err) e.be_cnt = 1;
      else if (!wr) begin
        e.lv_cnt = 1;
        v = rdata >> (8 * (addr % 4));
        case (nbytes)
          1: begin v = v & 32'hFF;   if (f3 == 3'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00; end
          2: begin v = v & 32'hFFFF; if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000; end
          default: v = rdata;
        endcase
        e.data = v;
      end
    end
    return e;
  endfunction

  // Drive one instruction through the MEM stage, acting as the memory, and
  // record what the controller did until three idle cycles after retirement.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err,
                         input int ready_dly, input int rsp_dly,
                         input logic kill_req, input logic kill_wait, output obs_t o);
    int hs_cyc, ready_wait, tail;
    logic released, killed;
    o = empty_obs();
    hs_cyc = -1; ready_wait = 0; tail = 0; released = 1'b0; killed = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      mem_read_i  = rd & ~released & ~killed;
      mem_write_i = wr & ~released & ~killed;
      funct3_i    = f3;
      addr_i      = addr;
      wdata_i     = wdata;
      kill_i      = 1'b0;
      bus_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_rdata_i = $urandom;
      rsp_err_i   = 1'($urandom_range(0, 1));
      if (bus_valid_o) begin
        if (kill_req) begin kill_i = 1'b1; killed = 1'b1; end
        else if (ready_wait >= ready_dly) bus_ready_i = 1'b1;
        ready_wait++;
      end
      if (hs_cyc >= 0 && cyc == hs_cyc + 1 && kill_wait) begin
        kill_i = 1'b1; killed = 1'b1;
      end
      if (hs_cyc >= 0 && cyc == hs_cyc + 1 + rsp_dly) begin
        rsp_valid_i = 1'b1; rsp_rdata_i = rdata; rsp_err_i = err;
      end
      @(negedge clk);
      if (stall_o)        o.stall_cycles++;
      if (misalign_exc_o) o.mis_cnt++;
      if (load_valid_o) begin o.lv_cnt++; o.data = load_data_o; o.ev_cyc = cyc; end
      if (bus_err_exc_o) begin o.be_cnt++; o.ev_cyc = cyc; end
      if (bus_valid_o) begin
        if (o.valid_cycles == 0) begin
          o.addr = bus_addr_o; o.wdata = bus_wdata_o; o.strb = bus_wstrb_o; o.we = bus_we_o;
        end else if (bus_addr_o !== o.addr || bus_wdata_o !== o.wdata ||
                     bus_wstrb_o !== o.strb || bus_we_o !== o.we) begin
          o.stable = 1'b0;
        end
        o.valid_cycles++;
        if (bus_ready_i) hs_cyc = cyc;
      end
      if (released) tail++;
      else if (!stall_o) released = 1'b1;
      if (tail >= 3) begin o.finished = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic compare_obs(input string name, input obs_t got, input obs_t exp);
    check({name, "_finished"}, got.finished, exp.finished);
    check({name, "_misalign"}, got.mis_cnt, exp.mis_cnt);
    check({name, "_stall"}, got.stall_cycles, exp.stall_cycles);
    check({name, "_valid_cycles"}, got.valid_cycles, exp.valid_cycles);
    check({name, "_load_valid"}, got.lv_cnt, exp.lv_cnt);
    check({name, "_bus_err"}, got.be_cnt, exp.be_cnt);
    if (exp.valid_cycles > 0) begin
      check({name, "_stable"}, got.stable, 1'b1);
      check({name, "_addr"}, got.addr, exp.addr);
      check({name, "_wstrb"}, got.strb, exp.strb);
      check({name, "_we"}, got.we, exp.we);
      if (exp.we) check({name, "_wdata"}, got.wdata, exp.wdata);
    end
    if (exp.lv_cnt > 0) check({name, "_load_data"}, got.data, exp.data);
    if (exp.lv_cnt > 0 || exp.be_cnt > 0) check({name, "_pulse_cycle"}, got.ev_cyc, exp.ev_cyc);
    if (exp.lv_cnt > 0) model_last = exp.data;
    check({name, "_data_hold"}, load_data_o, model_last);
  endtask

  vec_t vecs[15];
  obs_t got, exp_o;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd    wr    f3    addr          wdata         rdata         err  | mis  addr          strb     wdata         lv    data          be   stall
    vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h100, 4'b0000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 3};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h203, 32'h0,        32'h80123456, 1'b0, 1'b0, 32'h200, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h203, 32'h0,        32'h80123456, 1'b0, 1'b0, 32'h200, 4'b0000, 32'h0,        1'b1, 32'h00000080, 1'b0, 3};
    vecs[3]  = '{1'b1, 1'b0, 3'd5, 32'h202, 32'h0,        32'h1234ABCD, 1'b0, 1'b0, 32'h200, 4'b0000, 32'h0,        1'b1, 32'h00001234, 1'b0, 3};
    vecs[4]  = '{1'b1, 1'b0, 3'd1, 32'h200, 32'h0,        32'h1234ABCD, 1'b0, 1'b0, 32'h200, 4'b0000, 32'h0,        1'b1, 32'hFFFFABCD, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 32'h201, 32'h0,        32'h00007F00, 1'b0, 1'b0, 32'h200, 4'b0000, 32'h0,        1'b1, 32'h0000007F, 1'b0, 3};
    vecs[6]  = '{1'b0, 1'b1, 3'd0, 32'h011, 32'h000000A5, 32'h0,        1'b0, 1'b0, 32'h010, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 3};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 32'h012, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 32'h010, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0,        1'b0, 3};
    vecs[8]  = '{1'b0, 1'b1, 3'd2, 32'h020, 32'h12345678, 32'h0,        1'b0, 1'b0, 32'h020, 4'b1111, 32'h12345678, 1'b0, 32'h0,        1'b0, 3};
    vecs[9]  = '{1'b1, 1'b0, 3'd2, 32'h102, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 0};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 0};
    vecs[11] = '{1'b0, 1'b1, 3'd4, 32'h000, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 0};
    vecs[12] = '{1'b1, 1'b0, 3'd0, 32'h040, 32'h0,        32'h11223344, 1'b1, 1'b0, 32'h040, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 3};
    vecs[13] = '{1'b0, 1'b1, 3'd1, 32'h013, 32'h0000BEEF, 32'h0,        1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 0};
    vecs[14] = '{1'b1, 1'b1, 3'd2, 32'h030, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 32'h030, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 3};

    // Reset state, with a legal request already presented.
    rstn = 1'b0;
    mem_read_i = 1'b1; mem_write_i = 1'b0; kill_i = 1'b0; funct3_i = 3'd2;
    addr_i = 32'h100; wdata_i = '0; bus_ready_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_rdata_i = '0; rsp_err_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_stall", stall_o, 0);
    check("reset_bus_valid", bus_valid_o, 0);
    check("reset_misalign", misalign_exc_o, 0);
    check("reset_load_valid", load_valid_o, 0);
    check("reset_load_data", load_data_o, 0);
    check("reset_wstrb", bus_wstrb_o, 0);
    mem_read_i = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Table vectors with a zero-wait memory.
    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              vecs[i].rdata, vecs[i].err, 0, 0, 1'b0, 1'b0, got);
      exp_o = empty_obs();
      exp_o.finished     = 1'b1;
      exp_o.mis_cnt      = vecs[i].exp_mis;
      exp_o.valid_cycles = vecs[i].exp_mis ? 0 : 1;
      exp_o.addr         = vecs[i].exp_addr;
      exp_o.strb         = vecs[i].exp_strb;
      exp_o.wdata        = vecs[i].exp_wdata;
      exp_o.we           = vecs[i].wr;
      exp_o.stall_cycles = vecs[i].exp_stall;
      exp_o.lv_cnt       = vecs[i].exp_lv;
      exp_o.be_cnt       = vecs[i].exp_be;
      exp_o.data         = vecs[i].exp_data;
      exp_o.ev_cyc       = vecs[i].exp_stall;
      compare_obs($sformatf("vec%0d", i), got, exp_o);
    end

    // Ready held low for five cycles: request must stay stable.
    run_txn(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'h0BADF00D, 1'b0, 5, 0, 1'b0, 1'b0, got);
    check("rdy5_valid_cycles", got.valid_cycles, 6);
    check("rdy5_stable", got.stable, 1);
    check("rdy5_stall", got.stall_cycles, 8);
    check("rdy5_data", got.data, 32'h0BADF00D);
    model_last = 32'h0BADF00D;

    // Kill while still in REQ: valid drops, no pulses.
    run_txn(1'b1, 1'b0, 3'd2, 32'h304, 32'h0, 32'h0, 1'b0, 1, 0, 1'b1, 1'b0, got);
    check("killreq_valid_cycles", got.valid_cycles, 1);
    check("killreq_stall", got.stall_cycles, 2);
    check("killreq_pulses", got.lv_cnt + got.be_cnt + got.mis_cnt, 0);
    check("killreq_hold", load_data_o, model_last);

    // Kill during WAIT_RSP: transaction completes silently.
    run_txn(1'b1, 1'b0, 3'd2, 32'h308, 32'h0, 32'h77777777, 1'b0, 0, 1, 1'b0, 1'b1, got);
    check("killwait_stall", got.stall_cycles, 4);
    check("killwait_pulses", got.lv_cnt + got.be_cnt, 0);
    check("killwait_hold", load_data_o, model_last);

    // Timeout: response arrives only in the DONE cycle and is ignored.
    run_txn(1'b1, 1'b0, 3'd2, 32'h30C, 32'h0, 32'h66666666, 1'b0, 0, TIMEOUT, 1'b0, 1'b0, got);
    check("timeout_bus_err", got.be_cnt, 1);
    check("timeout_load_valid", got.lv_cnt, 0);
    check("timeout_stall", got.stall_cycles, 2 + TIMEOUT);
    check("timeout_pulse_cycle", got.ev_cyc, 2 + TIMEOUT);
    check("timeout_hold", load_data_o, model_last);

    // Response in the last waiting cycle still wins over the timeout.
    run_txn(1'b1, 1'b0, 3'd4, 32'h311, 32'h0, 32'h0000C300, 1'b0, 0, TIMEOUT - 1, 1'b0, 1'b0, got);
    check("lastwait_load_valid", got.lv_cnt, 1);
    check("lastwait_bus_err", got.be_cnt, 0);
    check("lastwait_data", got.data, 32'h000000C3);
    model_last = 32'h000000C3;

    // Reset asserted in WAIT_RSP, then a stray response.
    @(posedge clk); #1;
    mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h500;
    kill_i = 1'b0; bus_ready_i = 1'b0; rsp_valid_i = 1'b0;
    @(posedge clk); #1;
    bus_ready_i = 1'b1;
    @(negedge clk);
    check("rstmid_req_valid", bus_valid_o, 1);
    @(posedge clk); #1;
    bus_ready_i = 1'b0;
    @(negedge clk);
    check("rstmid_wait_stall", stall_o, 1);
    #1 rstn = 1'b0;
    #1;
    check("rstmid_stall", stall_o, 0);
    check("rstmid_bus_valid", bus_valid_o, 0);
    check("rstmid_bus_addr", bus_addr_o, 0);
    check("rstmid_load_data", load_data_o, 0);
    check("rstmid_pulses", {29'd0, load_valid_o, bus_err_exc_o, misalign_exc_o}, 0);
    model_last = '0;
    @(posedge clk); #1;
    rstn = 1'b1; mem_read_i = 1'b0;
    rsp_valid_i = 1'b1; rsp_rdata_i = 32'h55AA55AA; rsp_err_i = 1'b0;
    @(negedge clk);
    check("rstmid_after_stall", stall_o, 0);
    check("rstmid_after_valid", bus_valid_o, 0);
    @(posedge clk); #1;
    rsp_valid_i = 1'b0;
    @(negedge clk);
    check("rstmid_after_load_valid", load_valid_o, 0);
    check("rstmid_after_data", load_data_o, 0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        rd, wr, err, kr, kw;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rdata;
      int          op, rdy, rsp;
      op    = $urandom_range(0, 2);
      rd    = (op != 1);
      wr    = (op != 0);
      f3    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      if (!wr && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
      addr  = $urandom & 32'h0000_0FFF;
      wdata = $urandom;
      rdata = $urandom;
      err   = ($urandom_range(0, 7) == 0);
      rdy   = $urandom_range(0, 3);
      rsp   = $urandom_range(0, TIMEOUT + 1);
      kr    = ($urandom_range(0, 9) == 0);
      kw    = !kr && ($urandom_range(0, 9) == 0);
      run_txn(rd, wr, f3, addr, wdata, rdata, err, rdy, rsp, kr, kw, got);
      exp_o = model(rd, wr, f3, addr, wdata, rdata, err, rdy, rsp, kr, kw);
      compare_obs($sformatf("rnd%0d", n), got, exp_o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
